// File: rtl/axi4_lite_master_adapter_pkg.sv
// Shared types for the AXI4-Lite master adapter: response codes, FSM encoding
// and the captured request record.
package axi4_lite_master_adapter_pkg;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'd0,
    AXI_RESP_EXOKAY = 2'd1,
    AXI_RESP_SLVERR = 2'd2,
    AXI_RESP_DECERR = 2'd3
  } axi_resp_e;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WR_REQ  = 3'd1;
  localparam state_t ST_WR_RESP = 3'd2;
  localparam state_t ST_RD_REQ  = 3'd3;
  localparam state_t ST_RD_RESP = 3'd4;
  localparam state_t ST_RSP     = 3'd5;

  // Request fields are sized for the widest supported bus; narrower
  // instances use the low bits only.
  localparam int REQ_ADDR_MAX = 64;
  localparam int REQ_DATA_MAX = 64;
  localparam int REQ_STRB_MAX = 8;

  typedef struct packed {
    logic                    write;
    logic [REQ_ADDR_MAX-1:0] addr;
    logic [REQ_DATA_MAX-1:0] wdata;
    logic [REQ_STRB_MAX-1:0] wstrb;
    logic [2:0]              prot;
  } req_t;

  function automatic logic [1:0] resp_with_id_check(input logic id_ok, input logic [1:0] resp);
    return id_ok ? resp : AXI_RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi4_lite_master_adapter_if.sv
// AXI4-Lite manager-side bus bundle; master modport is the initiator view.
interface axi4_lite_master_adapter_if #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_COUNT = DATA_WIDTH / 8
);

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [BYTE_COUNT-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arprot, arvalid, input arready,
    input rid, rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arprot, arvalid, output arready,
    output rid, rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi4_lite_master_adapter.sv
// Single-outstanding command port to AXI4-Lite manager bridge. A request is
// captured, issued on AW+W or AR, and the B/R outcome is held on the rsp port.
module axi4_lite_master_adapter
  import axi4_lite_master_adapter_pkg::*;
#(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_ADDR_WIDTH = 12,
  parameter int AXI_DATA_WIDTH = 32,  // 32 or 64
  parameter int AXI_ID_VALUE   = 0,
  parameter int AXI_BYTE_COUNT = AXI_DATA_WIDTH / 8
) (
  input  logic                      aclk,
  input  logic                      reset,

  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [AXI_DATA_WIDTH-1:0] req_wdata,
  input  logic [AXI_BYTE_COUNT-1:0] req_wstrb,
  input  logic [2:0]                req_prot,

  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                rsp_resp,

  output state_t                    dbg_state,

  axi4_lite_master_adapter_if.master m_axi
);

  // Every channel transfers on a rising aclk edge where valid && ready. A
  // source never withdraws valid or changes payload before that edge; all
  // valids driven here are flops and all readies decode state only.

  localparam logic [AXI_ID_WIDTH-1:0] ID_CONST = AXI_ID_WIDTH'(AXI_ID_VALUE);

  state_t                    state_q, state_d;
  req_t                      cmd_q, cmd_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      arvalid_q, arvalid_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic [AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                rsp_resp_q, rsp_resp_d;

  logic aw_hs, w_hs, ar_hs;
  logic unused_cmd_bits;

  assign aw_hs = awvalid_q & m_axi.awready;
  assign w_hs  = wvalid_q & m_axi.wready;
  assign ar_hs = arvalid_q & m_axi.arready;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cmd_d.write = req_write;
          cmd_d.addr  = REQ_ADDR_MAX'(req_addr);
          cmd_d.wdata = REQ_DATA_MAX'(req_wdata);
          cmd_d.wstrb = REQ_STRB_MAX'(req_wstrb);
          cmd_d.prot  = req_prot;
          if (req_write) begin
            state_d   = ST_WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = ST_RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end

      ST_WR_REQ: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // AW and W complete independently; leave once both have transferred.
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d = ST_WR_RESP;
        end
      end

      ST_WR_RESP: begin
        if (m_axi.bvalid) begin
          rsp_resp_d  = resp_with_id_check(m_axi.bid == ID_CONST, m_axi.bresp);
          rsp_rdata_d = '0;
          state_d     = ST_RSP;
        end
      end

      ST_RD_REQ: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          state_d   = ST_RD_RESP;
        end
      end

      ST_RD_RESP: begin
        if (m_axi.rvalid) begin
          rsp_resp_d  = resp_with_id_check(m_axi.rid == ID_CONST, m_axi.rresp);
          rsp_rdata_d = m_axi.rdata;
          state_d     = ST_RSP;
        end
      end

      ST_RSP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        arvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RSP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign dbg_state = state_q;

  assign m_axi.awid    = ID_CONST;
  assign m_axi.awaddr  = cmd_q.addr[AXI_ADDR_WIDTH-1:0];
  assign m_axi.awprot  = cmd_q.prot;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = cmd_q.wdata[AXI_DATA_WIDTH-1:0];
  assign m_axi.wstrb   = cmd_q.wstrb[AXI_BYTE_COUNT-1:0];
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = (state_q == ST_WR_RESP);
  assign m_axi.arid    = ID_CONST;
  assign m_axi.araddr  = cmd_q.addr[AXI_ADDR_WIDTH-1:0];
  assign m_axi.arprot  = cmd_q.prot;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = (state_q == ST_RD_RESP);

  // Upper bits of the wide request record and the write flag are not needed
  // once the FSM has branched.
  assign unused_cmd_bits = ^cmd_q;

endmodule

// File: tb/tb_axi4_lite_master_adapter.sv
// Directed bench for axi4_lite_master_adapter: vector table of transactions
// against a delay-configurable AXI4-Lite slave model, plus reset corner cases.
module tb_axi4_lite_master_adapter;
  import axi4_lite_master_adapter_pkg::*;

  localparam int IDW = 1;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int BC  = 4;

  logic aclk = 1'b0;
  logic reset = 1'b1;
  always #5 aclk = ~aclk;

  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [BC-1:0] req_wstrb;
  logic [2:0]    req_prot;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  state_t        dbg_state;

  axi4_lite_master_adapter_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_COUNT(BC)) axi ();

  axi4_lite_master_adapter #(
    .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_VALUE(0), .AXI_BYTE_COUNT(BC)
  ) dut (
    .aclk(aclk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .dbg_state(dbg_state),
    .m_axi(axi)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- slave model configuration and observations ----------------
  int             cfg_aw_delay, cfg_w_delay, cfg_ar_delay, cfg_rsp_delay;
  logic [IDW-1:0] cfg_id;
  logic [1:0]     cfg_resp;
  logic [DW-1:0]  cfg_rdata;

  logic [AW-1:0]  cur_addr;
  logic [DW-1:0]  cur_wdata;
  logic [BC-1:0]  cur_wstrb;
  logic [2:0]     cur_prot;

  int             aw_beats, w_beats, ar_beats, stab_err;
  logic [AW-1:0]  seen_awaddr, seen_araddr;
  logic [DW-1:0]  seen_wdata;
  logic [BC-1:0]  seen_wstrb;
  logic [2:0]     seen_prot;

  initial begin : slave_model
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic p_aw, p_w, p_ar, aw_got, w_got, b_pend, r_pend;
    int aw_wait, w_wait, ar_wait, b_wait, r_wait;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
    axi.bvalid = 1'b0; axi.bid = '0; axi.bresp = '0;
    axi.rvalid = 1'b0; axi.rid = '0; axi.rresp = '0; axi.rdata = '0;
    p_aw = 0; p_w = 0; p_ar = 0; aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    forever begin
      @(negedge aclk);
      aw_hs = axi.awvalid && axi.awready;
      w_hs  = axi.wvalid && axi.wready;
      b_hs  = axi.bvalid && axi.bready;
      ar_hs = axi.arvalid && axi.arready;
      r_hs  = axi.rvalid && axi.rready;
      if (!reset) begin
        if (axi.awvalid && (axi.awaddr != cur_addr || axi.awprot != cur_prot)) stab_err++;
        if (axi.wvalid && (axi.wdata != cur_wdata || axi.wstrb != cur_wstrb)) stab_err++;
        if (axi.arvalid && (axi.araddr != cur_addr || axi.arprot != cur_prot)) stab_err++;
        if ((p_aw && !axi.awvalid) || (p_w && !axi.wvalid) || (p_ar && !axi.arvalid)) stab_err++;
        if (req_ready && (axi.bready || axi.rready)) stab_err++;
        p_aw = axi.awvalid && !aw_hs;
        p_w  = axi.wvalid && !w_hs;
        p_ar = axi.arvalid && !ar_hs;
      end else begin
        p_aw = 0; p_w = 0; p_ar = 0;
      end
      if (aw_hs) begin aw_beats++; seen_awaddr = axi.awaddr; seen_prot = axi.awprot; end
      if (w_hs)  begin w_beats++; seen_wdata = axi.wdata; seen_wstrb = axi.wstrb; end
      if (ar_hs) begin ar_beats++; seen_araddr = axi.araddr; seen_prot = axi.arprot; end

      @(posedge aclk);
      #1;
      if (reset) begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid = 1'b0; axi.rvalid = 1'b0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
      end else begin
        if (aw_hs) begin axi.awready = 1'b0; aw_wait = 0; aw_got = 1; end
        if (w_hs)  begin axi.wready = 1'b0; w_wait = 0; w_got = 1; end
        if (aw_got && w_got) begin b_pend = 1; b_wait = 0; aw_got = 0; w_got = 0; end
        if (ar_hs) begin axi.arready = 1'b0; ar_wait = 0; r_pend = 1; r_wait = 0; end
        if (b_hs)  begin axi.bvalid = 1'b0; b_pend = 0; end
        if (r_hs)  begin axi.rvalid = 1'b0; r_pend = 0; end

        if (axi.awvalid && !axi.awready) begin
          if (aw_wait >= cfg_aw_delay) axi.awready = 1'b1; else aw_wait++;
        end
        if (axi.wvalid && !axi.wready) begin
          if (w_wait >= cfg_w_delay) axi.wready = 1'b1; else w_wait++;
        end
        if (axi.arvalid && !axi.arready) begin
          if (ar_wait >= cfg_ar_delay) axi.arready = 1'b1; else ar_wait++;
        end
        if (b_pend && !axi.bvalid) begin
          if (b_wait >= cfg_rsp_delay) begin
            axi.bvalid = 1'b1; axi.bid = cfg_id; axi.bresp = cfg_resp;
          end else b_wait++;
        end
        if (r_pend && !axi.rvalid) begin
          if (r_wait >= cfg_rsp_delay) begin
            axi.rvalid = 1'b1; axi.rid = cfg_id; axi.rresp = cfg_resp; axi.rdata = cfg_rdata;
          end else r_wait++;
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic           write;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic [BC-1:0]  wstrb;
    logic [2:0]     prot;
    int             aw_d, w_d, ar_d, rsp_d;
    logic [IDW-1:0] id;
    logic [1:0]     resp;
    logic [DW-1:0]  rdata;
    int             hold;
    logic [1:0]     exp_resp;
    logic [DW-1:0]  exp_rdata;
    int             exp_lat;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  task automatic setup_txn(input vec_t v);
    cfg_aw_delay = v.aw_d; cfg_w_delay = v.w_d; cfg_ar_delay = v.ar_d; cfg_rsp_delay = v.rsp_d;
    cfg_id = v.id; cfg_resp = v.resp; cfg_rdata = v.rdata;
    cur_addr = v.addr; cur_wdata = v.wdata; cur_wstrb = v.wstrb; cur_prot = v.prot;
    aw_beats = 0; w_beats = 0; ar_beats = 0; stab_err = 0;
    req_write = v.write; req_addr = v.addr; req_wdata = v.wdata;
    req_wstrb = v.wstrb; req_prot = v.prot;
  endtask

  // Called at 1 time unit after a rising edge with the DUT idle.
  task automatic do_txn(input int idx, input vec_t v);
    int lat, rr_bad, hold_bad;
    logic got;
    logic [DW-1:0] rd0;
    logic [1:0] rs0;
    string p;
    p = $sformatf("v%0d_", idx);
    setup_txn(v);
    req_valid = 1'b1;
    chk({p, "req_ready_idle"}, 64'(req_ready), 64'd1);
    @(posedge aclk); #1;
    req_valid = 1'b0;
    chk({p, "issue_valids"}, 64'({axi.awvalid, axi.wvalid, axi.arvalid}), v.write ? 64'b110 : 64'b001);
    lat = 1; got = 1'b0; rr_bad = 0;
    while (!got && lat < 60) begin
      if (rsp_valid) got = 1'b1;
      else begin
        if (req_ready) rr_bad++;
        @(posedge aclk); #1;
        lat++;
      end
    end
    chk({p, "rsp_seen"}, 64'(got), 64'd1);
    chk({p, "latency"}, 64'(lat), 64'(v.exp_lat));
    chk({p, "req_ready_busy"}, 64'(rr_bad), 64'd0);
    chk({p, "rsp_resp"}, 64'(rsp_resp), 64'(v.exp_resp));
    chk({p, "rsp_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
    chk({p, "beats"}, 64'(aw_beats * 100 + w_beats * 10 + ar_beats), v.write ? 64'd110 : 64'd1);
    if (v.write) begin
      chk({p, "awaddr"}, 64'(seen_awaddr), 64'(v.addr));
      chk({p, "wdata"}, 64'(seen_wdata), 64'(v.wdata));
      chk({p, "wstrb"}, 64'(seen_wstrb), 64'(v.wstrb));
    end else begin
      chk({p, "araddr"}, 64'(seen_araddr), 64'(v.addr));
    end
    chk({p, "prot"}, 64'(seen_prot), 64'(v.prot));
    chk({p, "bus_stable"}, 64'(stab_err), 64'd0);
    if (v.hold > 0) begin
      hold_bad = 0; rd0 = rsp_rdata; rs0 = rsp_resp;
      req_valid = 1'b1;
      for (int i = 0; i < v.hold; i++) begin
        @(posedge aclk); #1;
        if (!rsp_valid || rsp_rdata != rd0 || rsp_resp != rs0 || req_ready) hold_bad++;
      end
      chk({p, "hold_stable"}, 64'(hold_bad), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge aclk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk({p, "rsp_done"}, 64'({rsp_valid, req_ready}), 64'b01);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t rv;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0; req_prot = '0;
    rsp_ready = 1'b0;
    cfg_aw_delay = 0; cfg_w_delay = 0; cfg_ar_delay = 0; cfg_rsp_delay = 0;
    cfg_id = '0; cfg_resp = '0; cfg_rdata = '0;
    cur_addr = '0; cur_wdata = '0; cur_wstrb = '0; cur_prot = '0;
    aw_beats = 0; w_beats = 0; ar_beats = 0; stab_err = 0;
    seen_awaddr = '0; seen_araddr = '0; seen_wdata = '0; seen_wstrb = '0; seen_prot = '0;

    //         wr    addr     wdata         strb  prot aw w ar rsp id    resp   rdata         hold exp_resp exp_rdata   lat
    vecs[0] = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 3'd0, 0, 0, 0, 0, 1'b0, 2'd0, 32'h0,        0, 2'd0, 32'h0,        3};
    vecs[1] = '{1'b1, 12'h020, 32'hCAFEF00D, 4'h3, 3'd2, 0, 3, 0, 0, 1'b0, 2'd0, 32'h0,        0, 2'd0, 32'h0,        6};
    vecs[2] = '{1'b0, 12'h024, 32'h0,        4'h0, 3'd0, 0, 0, 0, 4, 1'b0, 2'd0, 32'h12345678, 0, 2'd0, 32'h12345678, 7};
    vecs[3] = '{1'b0, 12'h030, 32'h0,        4'h0, 3'd1, 0, 0, 0, 0, 1'b0, 2'd3, 32'hA5A5A5A5, 5, 2'd3, 32'hA5A5A5A5, 3};
    vecs[4] = '{1'b1, 12'h040, 32'h01020304, 4'hF, 3'd0, 0, 0, 0, 0, 1'b1, 2'd0, 32'h0,        0, 2'd2, 32'h0,        3};
    vecs[5] = '{1'b1, 12'h044, 32'h55AA55AA, 4'hC, 3'd0, 2, 0, 0, 0, 1'b0, 2'd1, 32'h0,        0, 2'd1, 32'h0,        5};
    vecs[6] = '{1'b0, 12'h048, 32'h0,        4'h0, 3'd0, 0, 0, 2, 0, 1'b0, 2'd2, 32'h0BADF00D, 0, 2'd2, 32'h0BADF00D, 5};
    vecs[7] = '{1'b0, 12'h04C, 32'h0,        4'h0, 3'd0, 0, 0, 0, 0, 1'b1, 2'd0, 32'h11112222, 0, 2'd2, 32'h11112222, 3};
    vecs[8] = '{1'b1, 12'hFFC, 32'h80000001, 4'h8, 3'd5, 1, 1, 0, 2, 1'b0, 2'd0, 32'h0,        0, 2'd0, 32'h0,        6};

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_valids", 64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, rsp_valid}), 64'd0);
    chk("reset_rsp", 64'({rsp_rdata, rsp_resp}), 64'd0);
    chk("reset_cmd_regs", 64'({axi.awaddr, axi.wdata, axi.wstrb, axi.awprot}), 64'd0);
    #1 reset = 1'b0;
    @(posedge aclk); #1;
    chk("req_ready_after_reset", 64'(req_ready), 64'd1);

    for (int i = 0; i < NV; i++) begin
      do_txn(i, vecs[i]);
    end

    // Reset while a write is stalled in WR_REQ with awvalid high.
    rv = vecs[0];
    rv.addr = 12'h100; rv.wdata = 32'h0F0F0F0F; rv.aw_d = 20; rv.w_d = 20;
    setup_txn(rv);
    req_valid = 1'b1;
    @(posedge aclk); #1;
    req_valid = 1'b0;
    @(posedge aclk); #1;
    chk("pre_reset_awvalid", 64'({axi.awvalid, axi.wvalid}), 64'b11);
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_abort", 64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, rsp_valid}), 64'd0);
    @(posedge aclk); #1;
    @(posedge aclk); #2;
    reset = 1'b0;
    @(posedge aclk); #1;
    chk("req_ready_post_abort", 64'(req_ready), 64'd1);
    do_txn(99, vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
